// File: rtl/operand_entry_fsm.sv
// Pushbutton operand entry: synchronise and debounce an active-low key, then step
// through capture of operand A, operand B with carry-in, and a hold/show phase
// that presents a valid operand set to the downstream BCD adder.
module operand_entry_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [2:0] sw,
  input  logic       sw_cin,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic       cin,
  output logic       valid,
  output logic [1:0] phase
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StEnterA  = 2'd0;
  localparam logic [1:0] StEnterB  = 2'd1;
  localparam logic [1:0] StShow    = 2'd2;

  logic            sync1_q, sync2_q;
  logic            key_s;
  logic            db_q, db_d;
  logic            db_dly_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press;

  logic [1:0]      phase_q, phase_d;
  logic [2:0]      a_q, a_d;
  logic [2:0]      b_q, b_d;
  logic            cin_q, cin_d;
  logic            valid_q, valid_d;

  // Two-flop synchroniser for the asynchronous key; idles released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q;

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (key_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = key_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Debounce state and the delayed copy used for falling-edge (press) detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  // One-cycle pulse on the debounced high-to-low transition only.
  assign press = db_dly_q & ~db_q;

  // Entry state machine; outputs hold unless a press event arrives.
  always_comb begin
    phase_d = phase_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    valid_d = valid_q;
    case (phase_q)
      StEnterA: begin
        if (press) begin
          a_d     = sw;
          phase_d = StEnterB;
        end
      end
      StEnterB: begin
        if (press) begin
          b_d     = sw;
          cin_d   = sw_cin;
          valid_d = 1'b1;
          phase_d = StShow;
        end
      end
      StShow: begin
        if (press) begin
          a_d     = '0;
          b_d     = '0;
          cin_d   = 1'b0;
          valid_d = 1'b0;
          phase_d = StEnterA;
        end
      end
      default: begin
        // Unreachable encoding: recover unconditionally with a clean operand set.
        a_d     = '0;
        b_d     = '0;
        cin_d   = 1'b0;
        valid_d = 1'b0;
        phase_d = StEnterA;
      end
    endcase
  end

  // Registered state and operand outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= StEnterA;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign cin   = cin_q;
  assign valid = valid_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Scoreboard bench for operand_entry_fsm with DEBOUNCE_CYCLES = 4. Stimulus pushes
// the expected output set and the edge at which it must appear; a monitor pops an
// entry whenever the outputs change and checks both value and timing.
module tb_operand_entry_fsm;

  localparam int unsigned D = 4;
  localparam int unsigned Lat = D + 3;

  logic       clk;
  logic       rst_n;
  logic       key_n;
  logic [2:0] sw;
  logic       sw_cin;
  logic [2:0] a;
  logic [2:0] b;
  logic       cin;
  logic       valid;
  logic [1:0] phase;

  typedef struct {
    logic [9:0] vec;  // {a, b, cin, valid, phase}
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  operand_entry_fsm #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .sw     (sw),
    .sw_cin (sw_cin),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .valid  (valid),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] pack(input logic [2:0] pa, input logic [2:0] pb,
                                      input logic pc, input logic pv, input logic [1:0] pp);
    return {pa, pb, pc, pv, pp};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [9:0] v, input int at);
    exp_t e;
    e.vec = v;
    e.cyc = at;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Clean press held long enough to register, then a release long enough to re-arm.
  task automatic press_expect(input logic [2:0] s, input logic c, input logic [9:0] ev);
    @(posedge clk);
    #1;
    sw     = s;
    sw_cin = c;
    key_n  = 1'b0;
    push_exp(ev, cyc + Lat);
    tick(12);
    key_n = 1'b1;
    tick(12);
  endtask

  // Monitor: any change of the output set must match the head of the scoreboard.
  initial begin : monitor
    logic [9:0] prev, cur;
    exp_t       e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = pack(a, b, cin, valid, phase);
      if (!rst_n) begin
        prev = cur;
      end else if (cur !== prev) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change got=%h prev=%h at edge %0d", cur, prev, cyc);
        end else begin
          e = sbq.pop_front();
          checks++;
          if (cur !== e.vec) begin
            failures++;
            $display("FAIL output_value got=%h expected=%h at edge %0d", cur, e.vec, cyc);
          end
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL output_timing got edge %0d expected edge %0d", cyc, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tl;
    int t0;
    logic [2:0] held_b;

    rst_n  = 1'b0;
    key_n  = 1'b1;
    sw     = 3'd0;
    sw_cin = 1'b0;
    #1;
    chk("reset_outputs", pack(a, b, cin, valid, phase), 10'h000);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Full cycle: A, then B with carry-in, then clear.
    press_expect(3'd5, 1'b0, pack(3'd5, 3'd0, 1'b0, 1'b0, 2'd1));
    press_expect(3'd6, 1'b1, pack(3'd5, 3'd6, 1'b1, 1'b1, 2'd2));
    press_expect(3'd2, 1'b1, pack(3'd0, 3'd0, 1'b0, 1'b0, 2'd0));

    // Bounce shorter than the debounce window: no event.
    sw = 3'd1;
    @(posedge clk);
    #1;
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(2);
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(20);

    // Same bounce, then stable low: one event timed from the last transition.
    sw = 3'd3;
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(2);
    key_n = 1'b0;
    tl = cyc;
    push_exp(pack(3'd3, 3'd0, 1'b0, 1'b0, 2'd1), tl + Lat);
    tick(15);
    key_n = 1'b1;
    tick(12);

    // Held key for 100 cycles with switches changing every cycle: single capture.
    t0 = cyc;
    held_b = 3'((t0 + 6) * 5 + 1);
    push_exp(pack(3'd3, held_b, 1'b0, 1'b1, 2'd2), t0 + Lat);
    sw_cin = 1'b0;
    for (int i = 0; i < 100; i++) begin
      key_n = 1'b0;
      sw    = 3'(cyc * 5 + 1);
      tick(1);
    end
    key_n = 1'b1;
    tick(12);

    press_expect(3'd0, 1'b0, pack(3'd0, 3'd0, 1'b0, 1'b0, 2'd0));
    press_expect(3'd7, 1'b0, pack(3'd7, 3'd0, 1'b0, 1'b0, 2'd1));

    // Reset partway through a debounce count, asserted between clock edges.
    key_n = 1'b0;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_phase", {8'h00, phase}, 10'h000);
    chk("midreset_a", {7'h00, a}, 10'h000);
    key_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);

    // Key held low through reset release counts as a new press.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    key_n = 1'b0;
    sw    = 3'd4;
    tick(2);
    rst_n = 1'b1;
    t0 = cyc;
    push_exp(pack(3'd4, 3'd0, 1'b0, 1'b0, 2'd1), t0 + Lat);
    tick(12);
    key_n = 1'b1;
    tick(12);

    tick(5);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
